// File: rtl/asmi_readback_if.sv
// Signal bundle between the readback engine and its Rx/Tx/ASMI neighbours.
// The readback engine takes the master side; the surrounding logic takes the slave side.
interface asmi_readback_if;
    logic        read_start;
    logic        read_ACK;
    logic [13:0] num_blocks;
    logic [9:0]  tx_used;
    logic        tx_wrreq;
    logic [7:0]  tx_data;
    logic        page_ready;
    logic        page_ready_ACK;
    logic [15:0] page_sum;
    logic        read_done;
    logic        read_error;
    logic        read_done_ACK;
    logic [23:0] asmi_addr;
    logic        asmi_rden;
    logic        asmi_read;
    logic [7:0]  asmi_dataout;
    logic        asmi_data_valid;
    logic        asmi_busy;

    modport master (
        input  read_start, num_blocks, tx_used, page_ready_ACK, read_done_ACK,
               asmi_dataout, asmi_data_valid, asmi_busy,
        output read_ACK, tx_wrreq, tx_data, page_ready, page_sum, read_done,
               read_error, asmi_addr, asmi_rden, asmi_read
    );

    modport slave (
        output read_start, num_blocks, tx_used, page_ready_ACK, read_done_ACK,
               asmi_dataout, asmi_data_valid, asmi_busy,
        input  read_ACK, tx_wrreq, tx_data, page_ready, page_sum, read_done,
               read_error, asmi_addr, asmi_rden, asmi_read
    );
endinterface

// File: rtl/asmi_readback.sv
// Streams the EPCS16 user region into the Tx FIFO page by page (256 bytes),
// with a 16-bit byte sum per page and set/ACK page and end-of-run flags.
module asmi_readback #(
    parameter logic [23:0] START_ADDR = 24'h100000,
    parameter int          MAX_BLOCKS = 4096,
    parameter int          TX_ROOM    = 767,
    parameter int          TIMEOUT    = 4095
) (
    input  logic            clock,
    input  logic            reset_n,
    asmi_readback_if.master bus
);
    localparam logic [13:0] MAX_B      = 14'(MAX_BLOCKS);
    localparam logic [9:0]  ROOM_LIM   = 10'(TX_ROOM);
    localparam logic [11:0] TIMER_LAST = 12'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_ROOM,
        S_ISSUE,
        S_STREAM,
        S_DRAIN,
        S_PAGE,
        S_DONE
    } state_t;

    function automatic logic [7:0] bit_rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [13:0] blocks_q, blocks_d;
    logic [13:0] page_q, page_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [11:0] timer_q, timer_d;
    logic [23:0] addr_q, addr_d;
    logic        rden_q, rden_d;
    logic        rd_pulse_q, rd_pulse_d;
    logic        ack_q, ack_d;
    logic        wr_q, wr_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] sum_q, sum_d;
    logic        pready_q, pready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0]  rx_byte;

    assign rx_byte = bit_rev(bus.asmi_dataout);

    always_comb begin
        state_d    = state_q;
        blocks_d   = blocks_q;
        page_d     = page_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        rden_d     = rden_q;
        rd_pulse_d = 1'b0;
        ack_d      = 1'b0;
        wr_d       = 1'b0;
        data_d     = data_q;
        sum_d      = sum_q;
        pready_d   = pready_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.read_start) begin
                    blocks_d = (bus.num_blocks > MAX_B) ? MAX_B : bus.num_blocks;
                    page_d   = '0;
                    addr_d   = START_ADDR;
                    ack_d    = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (blocks_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ROOM;
                end
            end
            S_ROOM: begin
                // A page only starts when the whole 256 bytes fit in the Tx FIFO.
                if (!bus.asmi_busy && (bus.tx_used <= ROOM_LIM)) begin
                    rden_d     = 1'b1;
                    rd_pulse_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                sum_d   = '0;
                timer_d = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // A byte arriving on the expiry clock wins over the timeout.
                if (bus.asmi_data_valid) begin
                    wr_d    = 1'b1;
                    data_d  = rx_byte;
                    sum_d   = sum_q + {8'd0, rx_byte};
                    cnt_d   = cnt_q + 9'd1;
                    timer_d = '0;
                    if (cnt_q == 9'd255) begin
                        rden_d  = 1'b0;
                        state_d = S_DRAIN;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    rden_d  = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end
            S_DRAIN: begin
                if (!bus.asmi_busy) begin
                    page_d   = page_q + 14'd1;
                    addr_d   = addr_q + 24'd256;
                    pready_d = 1'b1;
                    state_d  = S_PAGE;
                end
            end
            S_PAGE: begin
                if (bus.page_ready_ACK) begin
                    pready_d = 1'b0;
                    if (page_q == blocks_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ROOM;
                    end
                end
            end
            S_DONE: begin
                if (bus.read_done_ACK) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Falling-edge state so the ASMI block sees stable controls on its rising edge.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            blocks_q   <= '0;
            page_q     <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            addr_q     <= START_ADDR;
            rden_q     <= 1'b0;
            rd_pulse_q <= 1'b0;
            ack_q      <= 1'b0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            sum_q      <= '0;
            pready_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            blocks_q   <= blocks_d;
            page_q     <= page_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            rden_q     <= rden_d;
            rd_pulse_q <= rd_pulse_d;
            ack_q      <= ack_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            sum_q      <= sum_d;
            pready_q   <= pready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.read_ACK   = ack_q;
    assign bus.tx_wrreq   = wr_q;
    assign bus.tx_data    = data_q;
    assign bus.page_ready = pready_q;
    assign bus.page_sum   = sum_q;
    assign bus.read_done  = done_q;
    assign bus.read_error = err_q;
    assign bus.asmi_addr  = addr_q;
    assign bus.asmi_rden  = rden_q;
    assign bus.asmi_read  = rd_pulse_q;
endmodule

// File: tb/tb_asmi_readback.sv
// Directed bench for asmi_readback: flash/ASMI model, Tx-side page ACK responder,
// and hand-computed expectations for each readback scenario.
module tb_asmi_readback;
    logic clock;
    logic reset_n;

    asmi_readback_if bus();

    asmi_readback #(.MAX_BLOCKS(6)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Written only by the monitor / model processes.
    int tx_wr_cnt = 0;
    int data_err  = 0;
    int pr_cnt    = 0;
    int read_cnt  = 0;
    logic [23:0] addr_log [0:31];
    logic [15:0] sum_log  [0:31];

    // Written only by the main sequence.
    int wr_base = 0;
    int derr_base = 0;
    int pr_base = 0;
    int rd_base = 0;
    int stop_after = 1000;
    int held_reads = 0;

    // Page k of the test image holds byte (offset >> k), so its sum is 128*(256/2^k - 1).
    logic [15:0] exp_sum [0:5] = '{16'h7F80, 16'h3F80, 16'h1F80, 16'h0F80, 16'h0780, 16'h0380};

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] >> a[10:8];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash / ASMI model: rising-edge behaviour, bit-reversed bytes, one idle clock in four.
    initial begin : flash_model
        bit          m_active;
        int          m_lat, m_drain, m_gap, m_sent;
        logic [23:0] m_addr;
        m_active = 0; m_lat = 0; m_drain = 0; m_gap = 0; m_sent = 0; m_addr = '0;
        bus.asmi_data_valid = 1'b0;
        bus.asmi_dataout    = 8'h00;
        bus.asmi_busy       = 1'b0;
        forever begin
            @(posedge clock);
            bus.asmi_data_valid = 1'b0;
            if (bus.asmi_read === 1'b1) begin
                addr_log[read_cnt % 32] = bus.asmi_addr;
                read_cnt++;
                m_active = 1; m_addr = bus.asmi_addr; m_lat = 2; m_sent = 0; m_gap = 0;
                bus.asmi_busy = 1'b1;
            end else if (m_active) begin
                if (bus.asmi_rden !== 1'b1) begin
                    m_active = 0;
                    m_drain  = 3;
                end else if (m_lat > 0) begin
                    m_lat--;
                end else begin
                    m_gap++;
                    if (m_sent < stop_after && (m_gap % 4) != 0) begin
                        bus.asmi_data_valid = 1'b1;
                        bus.asmi_dataout    = rev8(flash_byte(m_addr));
                        m_addr++;
                        m_sent++;
                    end
                end
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) bus.asmi_busy = 1'b0;
            end
        end
    end

    // Tx side: acknowledge page_ready three clocks after it is seen.
    initial begin : page_responder
        int ack_dly;
        ack_dly = 0;
        bus.page_ready_ACK = 1'b0;
        forever begin
            @(posedge clock);
            if (bus.page_ready === 1'b1) begin
                ack_dly++;
                bus.page_ready_ACK = (ack_dly >= 3);
            end else begin
                ack_dly = 0;
                bus.page_ready_ACK = 1'b0;
            end
        end
    end

    // Tx FIFO monitor: byte stream against the image, page sums logged on page_ready rise.
    initial begin : tx_monitor
        logic pr_prev;
        int   rel;
        pr_prev = 1'b0;
        forever begin
            @(posedge clock);
            if (bus.tx_wrreq === 1'b1) begin
                rel = tx_wr_cnt - wr_base;
                if (bus.tx_data !== flash_byte(24'h100000 + 24'(rel))) data_err++;
                tx_wr_cnt++;
            end
            if (bus.page_ready === 1'b1 && !pr_prev) begin
                sum_log[pr_cnt % 32] = bus.page_sum;
                pr_cnt++;
            end
            pr_prev = (bus.page_ready === 1'b1);
        end
    end

    task automatic mark();
        wr_base   = tx_wr_cnt;
        derr_base = data_err;
        pr_base   = pr_cnt;
        rd_base   = read_cnt;
    endtask

    task automatic start_run(input logic [13:0] nb, output int ack_lat);
        bus.num_blocks = nb;
        bus.read_start = 1'b1;
        ack_lat = 0;
        do begin
            @(posedge clock);
            ack_lat++;
        end while (bus.read_ACK !== 1'b1 && ack_lat < 20);
        bus.read_start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (bus.read_done !== 1'b1 && n < limit) begin
            @(posedge clock);
            n++;
        end
        check_eq("read_done", 32'(bus.read_done), 1);
    endtask

    task automatic ack_done();
        bus.read_done_ACK = 1'b1;
        @(posedge clock);
        bus.read_done_ACK = 1'b0;
        @(posedge clock);
        check_eq("done_clear", {30'd0, bus.read_done, bus.read_error}, 0);
    endtask

    function automatic logic [6:0] ctrl_outs();
        return {bus.read_ACK, bus.tx_wrreq, bus.page_ready, bus.read_done,
                bus.read_error, bus.asmi_rden, bus.asmi_read};
    endfunction

    initial begin : main
        int lat, n;
        reset_n = 1'b0;
        bus.read_start = 1'b0;
        bus.num_blocks = '0;
        bus.tx_used = '0;
        bus.read_done_ACK = 1'b0;
        repeat (3) @(posedge clock);

        check_eq("rst_ctrl", 32'(ctrl_outs()), 0);
        check_eq("rst_data", {8'd0, bus.tx_data, bus.page_sum}, 0);
        check_eq("rst_addr", 32'(bus.asmi_addr), 32'h100000);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // One page of 0x00..0xFF.
        mark();
        start_run(14'd1, lat);
        check_eq("ack_latency", lat, 1);
        n = 0;
        while (bus.asmi_read !== 1'b1 && n < 50) begin
            @(posedge clock);
            n++;
        end
        check_eq("read_latency", n, 2);
        wait_done(2000);
        check_eq("p1_error", 32'(bus.read_error), 0);
        check_eq("p1_wrreq", tx_wr_cnt - wr_base, 256);
        check_eq("p1_data", data_err - derr_base, 0);
        check_eq("p1_pages", pr_cnt - pr_base, 1);
        check_eq("p1_sum", 32'(sum_log[pr_base % 32]), 32'h7F80);
        check_eq("p1_reads", read_cnt - rd_base, 1);
        check_eq("p1_addr", 32'(addr_log[rd_base % 32]), 32'h100000);
        ack_done();

        // Three pages; FIFO exactly at the limit first, then full before page 2.
        bus.tx_used = 10'd767;
        mark();
        start_run(14'd3, lat);
        fork
            begin
                int r0, k;
                k = 0;
                while ((pr_cnt - pr_base) < 2 && k < 3000) begin
                    @(posedge clock);
                    k++;
                end
                bus.tx_used = 10'd800;
                r0 = read_cnt;
                repeat (25) @(posedge clock);
                bus.tx_used = 10'd768;
                repeat (25) @(posedge clock);
                held_reads = read_cnt - r0;
                bus.tx_used = 10'd0;
            end
            wait_done(5000);
        join
        check_eq("p3_hold_reads", held_reads, 0);
        check_eq("p3_reads", read_cnt - rd_base, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("p3_addr", 32'(addr_log[(rd_base + i) % 32]), 32'h100000 + 32'(i * 256));
            check_eq("p3_sum", 32'(sum_log[(pr_base + i) % 32]), 32'(exp_sum[i]));
        end
        check_eq("p3_pages", pr_cnt - pr_base, 3);
        check_eq("p3_wrreq", tx_wr_cnt - wr_base, 768);
        check_eq("p3_data", data_err - derr_base, 0);
        check_eq("p3_error", 32'(bus.read_error), 0);
        ack_done();

        // Zero pages: ACK then done, no flash traffic.
        mark();
        start_run(14'd0, lat);
        check_eq("z_ack_latency", lat, 1);
        wait_done(100);
        check_eq("z_reads", read_cnt - rd_base, 0);
        check_eq("z_wrreq", tx_wr_cnt - wr_base, 0);
        check_eq("z_pages", pr_cnt - pr_base, 0);
        check_eq("z_error", 32'(bus.read_error), 0);
        ack_done();

        // Request above the clamp (MAX_BLOCKS = 6 here).
        mark();
        start_run(14'd5000, lat);
        wait_done(8000);
        check_eq("c_pages", pr_cnt - pr_base, 6);
        check_eq("c_reads", read_cnt - rd_base, 6);
        check_eq("c_last_addr", 32'(addr_log[(rd_base + 5) % 32]), 32'h100500);
        check_eq("c_wrreq", tx_wr_cnt - wr_base, 1536);
        check_eq("c_data", data_err - derr_base, 0);
        for (int i = 0; i < 6; i++) begin
            check_eq("c_sum", 32'(sum_log[(pr_base + i) % 32]), 32'(exp_sum[i]));
        end
        check_eq("c_error", 32'(bus.read_error), 0);
        ack_done();

        // Flash goes silent after 100 bytes.
        stop_after = 100;
        mark();
        start_run(14'd1, lat);
        n = 0;
        while ((tx_wr_cnt - wr_base) < 100 && n < 1000) begin
            @(posedge clock);
            n++;
        end
        n = 0;
        while (bus.asmi_rden === 1'b1 && n < 6000) begin
            @(posedge clock);
            n++;
        end
        check_eq("t_window", 32'(n >= 4093 && n <= 4097), 1);
        wait_done(5);
        check_eq("t_error", 32'(bus.read_error), 1);
        check_eq("t_wrreq", tx_wr_cnt - wr_base, 100);
        check_eq("t_pages", pr_cnt - pr_base, 0);
        ack_done();
        stop_after = 1000;
        repeat (5) @(posedge clock);

        // Reset in the middle of a page, then a clean restart.
        mark();
        start_run(14'd1, lat);
        n = 0;
        while ((tx_wr_cnt - wr_base) < 20 && n < 1000) begin
            @(posedge clock);
            n++;
        end
        #2 reset_n = 1'b0;
        #1;
        check_eq("mr_ctrl", 32'(ctrl_outs()), 0);
        check_eq("mr_data", {8'd0, bus.tx_data, bus.page_sum}, 0);
        check_eq("mr_addr", 32'(bus.asmi_addr), 32'h100000);
        repeat (2) @(posedge clock);
        reset_n = 1'b1;
        repeat (8) @(posedge clock);
        check_eq("mr_no_page", pr_cnt - pr_base, 0);
        mark();
        start_run(14'd1, lat);
        wait_done(2000);
        check_eq("mr_addr_restart", 32'(addr_log[rd_base % 32]), 32'h100000);
        check_eq("mr_wrreq", tx_wr_cnt - wr_base, 256);
        check_eq("mr_sum", 32'(sum_log[pr_base % 32]), 32'h7F80);
        check_eq("mr_data_ok", data_err - derr_base, 0);
        ack_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/asmi_readback.md
# asmi_readback

Reads back the user region of the EPCS16 configuration flash through the ASMI parallel read port and streams it into the Tx FIFO, one 256-byte page at a time, so the PC can verify an image after programming. It is the read-side counterpart of the flash programming path and sits beside it on the same ASMI instance, selected when programming is idle. Each page carries a 16-bit byte sum. Per-page and end-of-run flags use the same set/ACK handshake style as the programming path.

## Interface

Parameters:
- START_ADDR, 24'h100000, first flash byte read (top 1 MB of EPCS16)
- MAX_BLOCKS, 4096, upper clamp on pages per run (1 MB)
- TX_ROOM, 767, maximum tx_used at which a page may start (1023 - 256)
- TIMEOUT, 4095, clocks without asmi_data_valid before abort

Ports:
- clock  in  1  system clock; all state updates on falling edge
- reset_n  in  1  asynchronous, active-low reset
- read_start  in  1  level request from Rx decoder to start a readback
- read_ACK  out  1  request seen
- num_blocks  in  14  pages to read; sampled when read_start accepted
- tx_used  in  10  Tx FIFO words used
- tx_wrreq  out  1  Tx FIFO write strobe
- tx_data  out  8  byte to Tx FIFO, bit order restored
- page_ready  out  1  page complete, page_sum valid
- page_ready_ACK  in  1  Tx has seen page_ready
- page_sum  out  16  mod-65536 sum of the page's tx_data bytes
- read_done  out  1  run finished
- read_error  out  1  run aborted by timeout; valid with read_done
- read_done_ACK  in  1  Tx has seen read_done
- asmi_addr  out  24  ASMI read address
- asmi_rden  out  1  ASMI read enable
- asmi_read  out  1  ASMI read start pulse
- asmi_dataout  in  8  ASMI read byte (bit-reversed)
- asmi_data_valid  in  1  ASMI byte strobe
- asmi_busy  in  1  ASMI busy

## Operation

- Reset: all outputs 0, asmi_addr = START_ADDR, state IDLE, counters 0.
- IDLE: if read_start, latch blocks = min(num_blocks, MAX_BLOCKS), page = 0, asmi_addr = START_ADDR, go ACK. If blocks = 0, go DONE directly after ACK.
- ACK: read_ACK = 1 one clock; go ROOM.
- ROOM: wait for !asmi_busy and tx_used <= TX_ROOM; then go ISSUE.
- ISSUE: asmi_rden = 1, asmi_read = 1 for exactly one clock; clear byte_count, page_sum, timer; go STREAM.
- STREAM: asmi_rden held 1. Per asmi_data_valid: tx_wrreq = 1 for that clock, tx_data = bit-reverse(asmi_dataout), page_sum += byte, byte_count += 1, timer cleared. At byte_count = 256 drop asmi_rden, go DRAIN. Timer reaching TIMEOUT: drop asmi_rden, set read_error, go DONE.
- DRAIN: wait !asmi_busy; page += 1; asmi_addr += 256; set page_ready; go PAGE.
- PAGE: hold page_ready and page_sum until page_ready_ACK, then clear page_ready; go DONE if page = blocks, else ROOM.
- DONE: read_done = 1 until read_done_ACK; then clear read_done and read_error, go IDLE.
- read_start while not IDLE: ignored. byte_count 9 bits, page 14 bits, sum wraps mod 2^16.

## Timing

- All registers update on clock falling edge; ASMI samples on rising edge.
- tx_wrreq is registered: asserts on the edge after the asmi_data_valid sample, exactly one pulse per valid byte; never more than 256 per page.
- Start-to-first-read: read_start -> read_ACK 1 clock later, asmi_read 2 clocks after that if room and not busy.
- page_ready rises the clock after asmi_busy low in DRAIN; page_sum stable from that edge until ACK.
- Simultaneous data_valid and timeout expiry: the byte is accepted, timer cleared.
- Reset mid-run: outputs drop asynchronously; asmi_rden low ends the ASMI read; no partial page flagged.

## Test plan

- Flash model preloaded 0x00..0xFF at 0x100000, num_blocks = 1 -> 256 tx_wrreq pulses, tx_data 0x00..0xFF in order, page_sum = 0x7F80, then read_done with read_error = 0.
- num_blocks = 3, tx_used held 800 for 50 clocks before page 2 -> no asmi_read while tx_used > 767; addresses 0x100000, 0x100100, 0x100200; three page_ready/ACK cycles.
- num_blocks = 0 -> read_ACK, then read_done with no asmi_read and no tx_wrreq.
- num_blocks = 5000 -> exactly 4096 page_ready events, last asmi_addr issued 0x1FFF00.
- Model stops asmi_data_valid after byte 100 -> after 4095 idle clocks asmi_rden low, read_done = 1, read_error = 1, 100 tx_wrreq pulses total.
- reset_n low during STREAM -> all outputs 0 immediately; next read_start restarts at 0x100000.
